// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding,
// default datapath widths and error-flag bit positions.
package psum_accumulator_pkg;

    localparam int unsigned PSUM_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 20;
    localparam int unsigned CH_W       = 2;

    localparam int unsigned ERR_OVF = 0;   // result FIFO overflow
    localparam int unsigned ERR_CNT = 1;   // channel-count mismatch

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/psum_accumulator_result_fifo.sv
// result_fifo: synchronous FIFO holding accumulated results.
//   clk, rst_n : clock, async active-low reset (contents cleared)
//   push/wdata : write request; dropped when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : head entry (storage flop, no extra latency)
//   full/empty : registered occupancy flags
module result_fifo #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Occupancy, pointer and storage update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty_q;
        // A pop in the same cycle frees the slot a full FIFO needs
        do_push  = push && (!full_q || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums per-input-channel partial sums from the PE and
// queues one result per output channel into a small result FIFO.
//   start_conv, cfg_ci, cfg_co : start a convolution, channel counts minus 1
//   p_valid_in, last_channel_in, end_conv_in, psum_in : PE stream
//   result_valid/ready/data/co : FIFO head handshake
//   busy, done, err            : status (err is sticky until next start)
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned PSUM_W     = PSUM_W_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_conv,
    input  logic [1:0]        cfg_ci,
    input  logic [1:0]        cfg_co,
    input  logic              p_valid_in,
    input  logic              last_channel_in,
    input  logic              end_conv_in,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result_data,
    output logic [1:0]        result_co,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int unsigned ENT_W = ACC_W + CH_W;
    localparam int unsigned EXT_W = ACC_W - PSUM_W;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CH_W-1:0]   ci_q, ci_d;
    logic [CH_W-1:0]   co_q, co_d;
    logic [CH_W-1:0]   ci_cfg_q, ci_cfg_d;
    logic [CH_W-1:0]   co_cfg_q, co_cfg_d;
    logic [1:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ACC_W-1:0]  psum_ext_c;
    logic [ACC_W-1:0]  sum_c;
    logic              accept_c, push_c, pop_c;
    logic [ENT_W-1:0]  fifo_rdata;
    logic              fifo_full, fifo_empty;

    assign psum_ext_c = {{EXT_W{psum_in[PSUM_W-1]}}, psum_in};
    assign sum_c      = acc_q + psum_ext_c;   // wraps modulo 2^ACC_W
    assign accept_c   = (state_q == ST_ACCUM) && p_valid_in;
    assign push_c     = accept_c && last_channel_in;
    assign pop_c      = !fifo_empty && result_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_conv)  state_d = ST_ACCUM;
            ST_ACCUM: if (end_conv_in) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with it
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Accumulator, channel counters, config latch and sticky errors
    always_comb begin
        acc_d    = acc_q;
        ci_d     = ci_q;
        co_d     = co_q;
        ci_cfg_d = ci_cfg_q;
        co_cfg_d = co_cfg_q;
        err_d    = err_q;
        if (state_q == ST_IDLE && start_conv) begin
            ci_cfg_d = cfg_ci;
            co_cfg_d = cfg_co;
            acc_d    = '0;
            ci_d     = '0;
            co_d     = '0;
            err_d    = '0;
        end else if (push_c) begin
            acc_d = '0;
            ci_d  = '0;
            co_d  = (co_q == co_cfg_q) ? '0 : co_q + CH_W'(1);
            if (ci_q != ci_cfg_q) begin
                err_d[ERR_CNT] = 1'b1;
            end
            if (fifo_full && !pop_c) begin
                err_d[ERR_OVF] = 1'b1;
            end
        end else if (accept_c) begin
            acc_d = sum_c;
            ci_d  = ci_q + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ci_q     <= '0;
            co_q     <= '0;
            ci_cfg_q <= '0;
            co_cfg_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ci_q     <= ci_d;
            co_q     <= co_d;
            ci_cfg_q <= ci_cfg_d;
            co_cfg_q <= co_cfg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .wdata ({sum_c, co_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign result_valid = !fifo_empty;
    assign result_data  = fifo_rdata[ENT_W-1:CH_W];
    assign result_co    = fifo_rdata[CH_W-1:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: single-channel vector table plus
// hand sequences for multi-channel, overflow and mid-operation reset.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_conv;
    logic [1:0]  cfg_ci, cfg_co;
    logic        p_valid_in, last_channel_in, end_conv_in;
    logic [15:0] psum_in;
    logic        result_valid, result_ready;
    logic [19:0] result_data;
    logic [1:0]  result_co;
    logic        busy, done;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_conv      (start_conv),
        .cfg_ci          (cfg_ci),
        .cfg_co          (cfg_co),
        .p_valid_in      (p_valid_in),
        .last_channel_in (last_channel_in),
        .end_conv_in     (end_conv_in),
        .psum_in         (psum_in),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_data     (result_data),
        .result_co       (result_co),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    typedef struct {
        logic [1:0] ci;
        int         n;
        int         p0, p1, p2, p3;
        int         exp_data;
        int         exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] ci, input int n, input int p0, input int p1,
                                input int p2, input int p3, input int ed, input int ee);
        vec_t v;
        v.ci = ci; v.n = n; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All drive tasks are entered and left on a falling edge
    task automatic start(input logic [1:0] ci, input logic [1:0] co);
        start_conv = 1'b1; cfg_ci = ci; cfg_co = co;
        @(negedge clk);
        start_conv = 1'b0;
    endtask

    task automatic send(input int v, input logic last, input logic endc);
        p_valid_in = 1'b1; psum_in = 16'(v); last_channel_in = last; end_conv_in = endc;
        @(negedge clk);
        p_valid_in = 1'b0; last_channel_in = 1'b0; end_conv_in = 1'b0;
    endtask

    task automatic pop_one();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic end_pulse();
        end_conv_in = 1'b1;
        @(negedge clk);
        end_conv_in = 1'b0;
    endtask

    task automatic check_head(input string name, input int data, input int co);
        check({name, "_valid"}, int'(result_valid), 1);
        check({name, "_data"}, int'($signed(result_data)), data);
        check({name, "_co"}, int'(result_co), co);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done"}, int'(seen), 1);
        @(negedge clk);
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_done_pulse"}, int'(done), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = mk(2'd1, 2, 5, 7, 0, 0, 12, 0);
        vecs[1] = mk(2'd3, 4, -32768, -32768, -32768, -32768, -131072, 0);
        vecs[2] = mk(2'd3, 2, 100, -250, 0, 0, -150, 2);
        vecs[3] = mk(2'd0, 1, -1, 0, 0, 0, -1, 0);
        vecs[4] = mk(2'd2, 3, 32767, 32767, 32767, 0, 98301, 0);
        vecs[5] = mk(2'd1, 3, 1, 2, 3, 0, 6, 2);

        rst_n = 1'b0; start_conv = 1'b0; cfg_ci = '0; cfg_co = '0;
        p_valid_in = 1'b0; last_channel_in = 1'b0; end_conv_in = 1'b0;
        psum_in = '0; result_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(result_valid), 0);
        check("rst_data", int'(result_data), 0);
        check("rst_co", int'(result_co), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // psum outside ACCUM is ignored
        send(50, 1'b1, 1'b0);
        check("idle_ignore_valid", int'(result_valid), 0);
        check("idle_ignore_busy", int'(busy), 0);

        // Two output channels, two input channels each
        start(2'd1, 2'd1);
        check("two_co_busy", int'(busy), 1);
        send(5, 1'b0, 1'b0);
        send(7, 1'b1, 1'b0);
        start(2'd0, 2'd0);  // ignored while not IDLE
        send(-3, 1'b0, 1'b0);
        send(10, 1'b1, 1'b0);
        check_head("two_co_r0", 12, 0);
        pop_one();
        check_head("two_co_r1", 7, 1);
        pop_one();
        check("two_co_empty", int'(result_valid), 0);
        check("two_co_err", int'(err), 0);
        end_pulse();
        wait_done("two_co");

        // Overflow: third push into a full FIFO with no pop
        start(2'd0, 2'd3);
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        check("ovf_err", int'(err), 1);
        check_head("ovf_r0", 1, 0);
        pop_one();
        check_head("ovf_r1", 2, 1);
        pop_one();
        check("ovf_empty", int'(result_valid), 0);
        end_pulse();
        wait_done("ovf");
        check("ovf_err_sticky", int'(err), 1);

        // Asynchronous reset with one result queued
        start(2'd0, 2'd0);
        send(9, 1'b1, 1'b0);
        check_head("prerst", 9, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(result_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_data", int'(result_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(2'd0, 2'd0);
        send(4, 1'b1, 1'b1);
        check_head("postrst", 4, 0);
        pop_one();
        wait_done("postrst");

        // Single-channel table; last psum coincides with end_conv_in
        for (int k = 0; k < 6; k++) begin
            int ps[4];
            ps[0] = vecs[k].p0; ps[1] = vecs[k].p1; ps[2] = vecs[k].p2; ps[3] = vecs[k].p3;
            start(vecs[k].ci, 2'd0);
            for (int i = 0; i < vecs[k].n; i++) begin
                send(ps[i], logic'(i == vecs[k].n - 1), logic'(i == vecs[k].n - 1));
            end
            check_head($sformatf("vec%0d", k), vecs[k].exp_data, 0);
            check($sformatf("vec%0d_err", k), int'(err), vecs[k].exp_err);
            check($sformatf("vec%0d_busy", k), int'(busy), 1);
            pop_one();
            wait_done($sformatf("vec%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
